// File: rtl/t5_fetch.sv
// T5 RV32 fetch stage: Wishbone classic master, one request in flight, zero-latency ack-to-decode path.
// Backpressure: sstall during an ack parks the word in ibuf and drops strobe until decode takes it.
// Optional T5_FETCH_MISALIGN_EN: misaligned redirect raises fmis and parks fetch in STOP.
`timescale 1ns/1ps
module t5_fetch #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            xbra,
    input  logic [XLEN-1:0] xtgt,
    input  logic            sstall,
    output logic [XLEN-1:0] fpc,
    output logic [XLEN-1:0] finst,
    output logic            sena,
`ifdef T5_FETCH_MISALIGN_EN
    output logic            fmis,
`endif
    output logic [XLEN-1:0] iwb_adr,
    output logic            iwb_cyc,
    output logic            iwb_stb,
    output logic            iwb_we,
    output logic [3:0]      iwb_sel,
    input  logic [XLEN-1:0] iwb_dat,
    input  logic            iwb_ack
);

`ifdef T5_FETCH_MISALIGN_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FLUSH, S_HOLD, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH, S_HOLD} state_t;
`endif

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    state_t          state_q, state_d;
    logic [XLEN-1:0] npc_q, npc_d;
    logic [XLEN-1:0] adr_q, adr_d;
    logic [XLEN-1:0] ibuf_q, ibuf_d;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] npc_inc;

`ifdef T5_FETCH_MISALIGN_EN
    logic fmis_q, fmis_d;
    logic mis;
    assign tgt  = xtgt;
    assign mis  = xbra && (xtgt[1:0] != 2'b00);
    assign fmis = fmis_q;
`else
    assign tgt = xtgt & ~32'h3;
`endif

    // Only bits [31:2] count; the carry out of bit 31 is dropped for natural wrap.
    assign npc_inc = {npc_q[XLEN-1:2] + {{(XLEN-3){1'b0}}, 1'b1}, 2'b00};

    assign iwb_adr = adr_q;
    assign fpc     = adr_q;
    assign iwb_we  = 1'b0;
    assign iwb_sel = 4'hF;

    always_comb begin
        state_d = state_q;
        npc_d   = npc_q;
        adr_d   = adr_q;
        ibuf_d  = ibuf_q;
`ifdef T5_FETCH_MISALIGN_EN
        fmis_d  = fmis_q;
`endif
        iwb_cyc = 1'b0;
        iwb_stb = 1'b0;
        sena    = 1'b0;
        finst   = ibuf_q;
        case (state_q)
            S_IDLE: begin
                adr_d   = npc_q;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                iwb_cyc = 1'b1;
                iwb_stb = 1'b1;
                finst   = iwb_dat;
                if (xbra && iwb_ack) begin
                    adr_d = tgt;
                    npc_d = tgt;
                end else if (xbra) begin
                    // Address must stay put until the slave ends the cycle.
                    npc_d   = tgt;
                    state_d = S_FLUSH;
                end else if (iwb_ack && sstall) begin
                    ibuf_d  = iwb_dat;
                    state_d = S_HOLD;
                end else if (iwb_ack) begin
                    sena  = 1'b1;
                    adr_d = npc_inc;
                    npc_d = npc_inc;
                end
            end
            S_FLUSH: begin
                iwb_cyc = 1'b1;
                iwb_stb = 1'b1;
                finst   = iwb_dat;
                if (xbra)
                    npc_d = tgt;
                if (iwb_ack) begin
                    adr_d   = xbra ? tgt : npc_q;
                    state_d = S_FETCH;
                end
            end
            S_HOLD: begin
                sena = !sstall && !xbra;
                if (xbra) begin
                    adr_d   = tgt;
                    npc_d   = tgt;
                    state_d = S_FETCH;
                end else if (!sstall) begin
                    adr_d   = npc_inc;
                    npc_d   = npc_inc;
                    state_d = S_FETCH;
                end
            end
`ifdef T5_FETCH_MISALIGN_EN
            S_STOP: begin
                if (xbra) begin
                    fmis_d  = 1'b0;
                    adr_d   = tgt;
                    npc_d   = tgt;
                    state_d = S_FETCH;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef T5_FETCH_MISALIGN_EN
        // A misaligned redirect beats everything else once fetch is running.
        if (mis && state_q != S_IDLE) begin
            npc_d   = xtgt;
            fmis_d  = 1'b1;
            sena    = 1'b0;
            state_d = S_STOP;
        end
`endif
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state_q <= S_IDLE;
            npc_q   <= RESET_VECTOR;
            adr_q   <= RESET_VECTOR;
            ibuf_q  <= NOP;
`ifdef T5_FETCH_MISALIGN_EN
            fmis_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
            adr_q   <= adr_d;
            ibuf_q  <= ibuf_d;
`ifdef T5_FETCH_MISALIGN_EN
            fmis_q  <= fmis_d;
`endif
        end
    end

endmodule

// File: tb/tb_t5_fetch.sv
// Bench for t5_fetch: directed test-plan sequence with literal checks, then random traffic,
// all cycles compared against a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_t5_fetch;

    logic        sclk = 1'b0;
    logic        srst = 1'b1;
    logic        xbra = 1'b0;
    logic [31:0] xtgt = 32'h0;
    logic        sstall = 1'b0;
    logic [31:0] iwb_dat = 32'h0;
    logic        iwb_ack = 1'b0;
    logic [31:0] fpc, finst, iwb_adr;
    logic        sena, iwb_cyc, iwb_stb, iwb_we;
    logic [3:0]  iwb_sel;
`ifdef T5_FETCH_MISALIGN_EN
    logic        fmis;
`endif

    t5_fetch #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
        .sclk(sclk), .srst(srst), .xbra(xbra), .xtgt(xtgt), .sstall(sstall),
        .fpc(fpc), .finst(finst), .sena(sena),
`ifdef T5_FETCH_MISALIGN_EN
        .fmis(fmis),
`endif
        .iwb_adr(iwb_adr), .iwb_cyc(iwb_cyc), .iwb_stb(iwb_stb), .iwb_we(iwb_we),
        .iwb_sel(iwb_sel), .iwb_dat(iwb_dat), .iwb_ack(iwb_ack)
    );

    always #5 sclk = ~sclk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: where the next fetch is, whether the in-flight word is dead, and any parked word.
    bit          m_started = 0, m_held = 0, m_flush = 0, m_stop = 0;
    logic [31:0] m_addr = 32'h0, m_next = 32'h0, m_hdat = 32'h0;

    always @(negedge sclk) begin : cmp
        logic [31:0] tg;
        bit mis, e_cyc, e_sena;
        if (srst) begin
            m_started = 0; m_held = 0; m_flush = 0; m_stop = 0; m_addr = 32'h0;
            chk("m_rst_cyc", {31'd0, iwb_cyc}, 32'd0);
            chk("m_rst_sena", {31'd0, sena}, 32'd0);
            chk("m_rst_adr", iwb_adr, 32'h0);
        end else begin
`ifdef T5_FETCH_MISALIGN_EN
            tg  = xtgt;
            mis = xbra && (xtgt[1:0] != 2'b00);
`else
            tg  = {xtgt[31:2], 2'b00};
            mis = 1'b0;
`endif
            e_cyc = 1'b0;
            e_sena = 1'b0;
            if (!m_started) begin
                chk("m_idle_adr", iwb_adr, m_addr);
            end else if (m_stop) begin
                e_cyc = 1'b0;
            end else if (m_held) begin
                e_sena = !sstall && !xbra;
                chk("m_hold_adr", iwb_adr, m_addr);
                chk("m_hold_finst", finst, m_hdat);
            end else begin
                e_cyc = 1'b1;
                e_sena = iwb_ack && !xbra && !m_flush && !sstall;
                chk("m_bus_adr", iwb_adr, m_addr);
                if (e_sena) chk("m_finst", finst, iwb_dat);
            end
            if (m_started && !m_stop) chk("m_fpc", fpc, m_addr);
            chk("m_cyc", {31'd0, iwb_cyc}, {31'd0, e_cyc});
            chk("m_stb", {31'd0, iwb_stb}, {31'd0, e_cyc});
            chk("m_sena", {31'd0, sena}, {31'd0, e_sena});
            chk("m_we_sel", {27'd0, iwb_we, iwb_sel}, 32'h0000_000F);
`ifdef T5_FETCH_MISALIGN_EN
            chk("m_fmis", {31'd0, fmis}, {31'd0, m_stop});
`endif
            if (!m_started) begin
                m_started = 1;
            end else if (mis) begin
                m_stop = 1; m_held = 0; m_flush = 0;
            end else if (m_stop) begin
                if (xbra) begin m_stop = 0; m_addr = tg; end
            end else if (m_held) begin
                if (xbra) begin m_held = 0; m_addr = tg; end
                else if (!sstall) begin m_held = 0; m_addr = m_addr + 32'd4; end
            end else if (iwb_ack) begin
                if (xbra) begin m_addr = tg; m_flush = 0; end
                else if (m_flush) begin m_addr = m_next; m_flush = 0; end
                else if (sstall) begin m_held = 1; m_hdat = iwb_dat; end
                else m_addr = m_addr + 32'd4;
            end else if (xbra) begin
                m_flush = 1; m_next = tg;
            end
        end
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic drv(input bit a, input logic [31:0] d, input bit st, input bit b, input logic [31:0] t);
        iwb_ack = a; iwb_dat = d; sstall = st; xbra = b; xtgt = t;
        #1;
    endtask

    initial begin
        srst = 1'b1;
        repeat (3) step();
        #1;
        chk("rst_cyc", {31'd0, iwb_cyc}, 32'd0);
        chk("rst_adr", iwb_adr, 32'h0);
        chk("rst_sena", {31'd0, sena}, 32'd0);
        step(); srst = 1'b0; #1;
        chk("idle_stb", {31'd0, iwb_stb}, 32'd0);
        step(); drv(0, 32'h0, 0, 0, 32'h0);
        chk("first_adr", iwb_adr, 32'h0);
        chk("first_stb", {31'd0, iwb_stb}, 32'd1);
        step(); drv(1, 32'h1111_0001, 0, 0, 32'h0);
        chk("ack0_sena", {31'd0, sena}, 32'd1);
        chk("ack0_fpc", fpc, 32'h0);
        chk("ack0_finst", finst, 32'h1111_0001);
        step(); drv(1, 32'h1111_0002, 0, 0, 32'h0);
        chk("ack4_fpc", fpc, 32'h4);
        chk("ack4_sena", {31'd0, sena}, 32'd1);
        step(); drv(1, 32'h00A0_0093, 1, 0, 32'h0);
        chk("stall_ack_sena", {31'd0, sena}, 32'd0);
        chk("stall_ack_adr", iwb_adr, 32'h8);
        repeat (2) begin
            step(); drv(0, 32'hBAD0_BAD0, 1, 0, 32'h0);
            chk("hold_stb", {31'd0, iwb_stb}, 32'd0);
            chk("hold_finst", finst, 32'h00A0_0093);
            chk("hold_sena", {31'd0, sena}, 32'd0);
        end
        step(); drv(0, 32'h0, 0, 0, 32'h0);
        chk("release_sena", {31'd0, sena}, 32'd1);
        chk("release_fpc", fpc, 32'h8);
        chk("release_finst", finst, 32'h00A0_0093);
        step(); drv(1, 32'h2222_000C, 0, 0, 32'h0);
        chk("after_hold_adr", iwb_adr, 32'hC);
        chk("after_hold_sena", {31'd0, sena}, 32'd1);
        step(); drv(0, 32'h0, 0, 1, 32'h100);
        chk("flush_req_adr", iwb_adr, 32'h10);
        step(); drv(0, 32'h0, 0, 0, 32'h0);
        chk("flush_adr_held", iwb_adr, 32'h10);
        chk("flush_stb", {31'd0, iwb_stb}, 32'd1);
        step(); drv(1, 32'hDEAD_0010, 0, 0, 32'h0);
        chk("flush_ack_sena", {31'd0, sena}, 32'd0);
        step(); drv(1, 32'h3333_0100, 0, 1, 32'h20);
        chk("redir_adr_100", iwb_adr, 32'h100);
        chk("redir_ack_sena", {31'd0, sena}, 32'd0);
        step(); drv(1, 32'h3333_0020, 0, 1, 32'h200);
        chk("redir_adr_20", iwb_adr, 32'h20);
        chk("redir20_sena", {31'd0, sena}, 32'd0);
        step(); drv(1, 32'h0, 0, 1, 32'hFFFF_FFFC);
        chk("redir_adr_200", iwb_adr, 32'h200);
        step(); drv(1, 32'h4444_FFFC, 0, 0, 32'h0);
        chk("top_adr", iwb_adr, 32'hFFFF_FFFC);
        chk("top_sena", {31'd0, sena}, 32'd1);
        step(); drv(0, 32'h0, 0, 0, 32'h0);
        chk("wrap_adr", iwb_adr, 32'h0);
`ifdef T5_FETCH_MISALIGN_EN
        drv(0, 32'h0, 0, 1, 32'h102);
        step(); drv(0, 32'h0, 0, 0, 32'h0);
        chk("mis_fmis", {31'd0, fmis}, 32'd1);
        chk("mis_stb", {31'd0, iwb_stb}, 32'd0);
        chk("mis_sena", {31'd0, sena}, 32'd0);
        drv(0, 32'h0, 0, 1, 32'h104);
        step(); drv(0, 32'h0, 0, 0, 32'h0);
        chk("resume_fmis", {31'd0, fmis}, 32'd0);
        chk("resume_adr", iwb_adr, 32'h104);
`else
        drv(1, 32'h0, 0, 1, 32'h103);
        step(); drv(0, 32'h0, 0, 0, 32'h0);
        chk("mask_adr", iwb_adr, 32'h100);
`endif
        // Reset in the middle of a pending bus cycle, then a late ack.
        srst = 1'b1; #1;
        chk("async_rst_cyc", {31'd0, iwb_cyc}, 32'd0);
        step(); drv(1, 32'h5555_5555, 0, 0, 32'h0);
        chk("late_ack_sena", {31'd0, sena}, 32'd0);
        chk("late_ack_cyc", {31'd0, iwb_cyc}, 32'd0);
        step(); srst = 1'b0; drv(0, 32'h0, 0, 0, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            step();
            srst    = ($urandom_range(0, 399) == 0);
            iwb_ack = iwb_cyc && ($urandom_range(0, 2) != 0);
            iwb_dat = $urandom;
            sstall  = ($urandom_range(0, 3) == 0);
            xbra    = ($urandom_range(0, 7) == 0);
            xtgt    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                  : 32'($urandom);
            if ($urandom_range(0, 3) != 0) xtgt[1:0] = 2'b00;
        end
        step();
        srst = 1'b0; xbra = 1'b0; iwb_ack = 1'b0;
        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
